// File: rtl/add_1p_arbiter_pkg.sv
// Shared constants and types for the add_1p round-robin arbiter.
package add_arb_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_LAT  = 1;
  localparam int unsigned IDXW     = $clog2(DEF_NREQ);

  // Ownership tag that travels alongside each in-flight sum
  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
  } tag_t;

endpackage

// File: rtl/add_1p_arbiter_if.sv
// Requester-side bundle: per-requester request/response handshakes plus idle.
interface add_1p_arbiter_if
  import add_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = 16
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*WIDTH-1:0] rsp_sum;
  logic                  idle;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, idle
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, idle
  );

endinterface

// File: rtl/add_1p.sv
// One-stage pipelined adder: low segment and its carry are registered, high
// segment is finished after the register. No valid, no reset.
module add_1p #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LSB_WIDTH = 8,
  parameter int unsigned MSB_WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  logic [LSB_WIDTH:0]   lsb_d, lsb_q;
  logic [MSB_WIDTH-1:0] msb_x_d, msb_x_q;
  logic [MSB_WIDTH-1:0] msb_y_d, msb_y_q;

  // Low-segment add and high-segment operand split
  always_comb begin
    lsb_d   = {1'b0, x[LSB_WIDTH-1:0]} + {1'b0, y[LSB_WIDTH-1:0]};
    msb_x_d = x[WIDTH-1 -: MSB_WIDTH];
    msb_y_d = y[WIDTH-1 -: MSB_WIDTH];
  end

  // Pipeline register between the two segments
  always_ff @(posedge clk) begin
    lsb_q   <= lsb_d;
    msb_x_q <= msb_x_d;
    msb_y_q <= msb_y_d;
  end

  assign sum = {msb_x_q + msb_y_q + MSB_WIDTH'(lsb_q[LSB_WIDTH]), lsb_q[LSB_WIDTH-1:0]};

endmodule

// File: rtl/add_1p_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above ptr, with wrap.
module rr_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W_IDX = IDXW
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [W_IDX-1:0] ptr,
  output logic [NREQ-1:0]  grant_c,
  output logic [W_IDX-1:0] grant_idx_c,
  output logic             grant_valid_c
);

  logic [W_IDX-1:0] cand;

  // Upward search from ptr; the first hit wins
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    cand          = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = W_IDX'((32'(ptr) + i) % NREQ);
      if (!grant_valid_c && eligible[cand]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = cand;
        grant_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_1p_arbiter.sv
// Shares one add_1p between NREQ requesters; tags track ownership of each sum.
module add_1p_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LSB_WIDTH = 8,
  parameter int unsigned MSB_WIDTH = 8,
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned LAT       = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  add_1p_arbiter_if.slave  bus
);

  logic [NREQ-1:0]       busy_d, busy_q;
  logic [NREQ-1:0]       rsp_valid_d, rsp_valid_q;
  logic [NREQ*WIDTH-1:0] rsp_sum_d, rsp_sum_q;
  logic [IDXW-1:0]       ptr_d, ptr_q;
  logic                  idle_d, idle_q;
  tag_t                  tag_d [LAT];
  tag_t                  tag_q [LAT];

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  gnt_oh;
  logic [IDXW-1:0]  gnt_idx;
  logic             gnt_valid;
  logic [NREQ-1:0]  rsp_hs;
  logic [WIDTH-1:0] add_x, add_y, add_sum;
  logic             any_tag;

  assign eligible = bus.req_valid & ~busy_q;
  assign rsp_hs   = rsp_valid_q & bus.rsp_ready;

  rr_arbiter #(
    .NREQ  (NREQ),
    .W_IDX (IDXW)
  ) u_rr (
    .eligible      (eligible),
    .ptr           (ptr_q),
    .grant_c       (gnt_oh),
    .grant_idx_c   (gnt_idx),
    .grant_valid_c (gnt_valid)
  );

  // Operand mux from the granted requester; zero when nobody is granted
  always_comb begin
    add_x = '0;
    add_y = '0;
    if (gnt_valid) begin
      add_x = bus.req_x[32'(gnt_idx)*WIDTH +: WIDTH];
      add_y = bus.req_y[32'(gnt_idx)*WIDTH +: WIDTH];
    end
  end

  add_1p #(
    .WIDTH     (WIDTH),
    .LSB_WIDTH (LSB_WIDTH),
    .MSB_WIDTH (MSB_WIDTH)
  ) u_add (
    .clk (clk),
    .x   (add_x),
    .y   (add_y),
    .sum (add_sum)
  );

  // Slot bookkeeping, result capture, tag shift and pointer advance
  always_comb begin
    busy_d      = (busy_q & ~rsp_hs) | gnt_oh;
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_sum_d   = rsp_sum_q;
    ptr_d       = ptr_q;
    tag_d       = tag_q;
    any_tag     = 1'b0;

    if (tag_q[LAT-1].valid) begin
      rsp_valid_d[tag_q[LAT-1].idx] = 1'b1;
      rsp_sum_d[32'(tag_q[LAT-1].idx)*WIDTH +: WIDTH] = add_sum;
    end

    for (int unsigned s = LAT - 1; s > 0; s--) begin
      tag_d[s] = tag_q[s-1];
    end
    tag_d[0].valid = gnt_valid;
    tag_d[0].idx   = gnt_idx;

    if (gnt_valid) begin
      ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDXW'(1);
    end

    for (int unsigned s = 0; s < LAT; s++) begin
      any_tag = any_tag | tag_d[s].valid;
    end
    idle_d = ~(|busy_d) & ~any_tag;
  end

  // State registers; reset discards in-flight tags and buffered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      ptr_q       <= '0;
      idle_q      <= 1'b1;
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      ptr_q       <= ptr_d;
      idle_q      <= idle_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.req_ready = gnt_oh & {NREQ{rst_n}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.idle      = idle_q;

endmodule

// File: tb/tb_add_1p_arbiter.sv
// Directed and random checks for add_1p_arbiter with a handshake scoreboard.
module tb_add_1p_arbiter;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic        pend_v   [N];
  logic [15:0] pend_sum [N];

  add_1p_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

  add_1p_arbiter #(
    .WIDTH(W), .LSB_WIDTH(8), .MSB_WIDTH(8), .NREQ(N), .LAT(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sum_of(input int i);
    return bus.rsp_sum[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: record operands at request handshake, compare at response handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          chk("sb_pending", 32'(pend_v[i]), 32'd1);
          if (pend_v[i]) chk("sb_sum", 32'(sum_of(i)), 32'(pend_sum[i]));
          pend_v[i] = 1'b0;
        end
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          chk("sb_one_inflight", 32'(pend_v[i]), 32'd0);
          pend_v[i]   = 1'b1;
          pend_sum[i] = bus.req_x[i*W +: W] + bus.req_y[i*W +: W];
        end
      end
    end
  end

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    rst_n = 1'b0;
    smp();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_sum", bus.rsp_sum[31:0], 32'd0);
    chk("rst_idle", 32'(bus.idle), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_op(input int i, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << i;
    bus.req_x[i*W +: W] = x;
    bus.req_y[i*W +: W] = y;
    bus.req_valid[i] = 1'b1;
    smp();
    n = 0;
    while (!bus.req_ready[i] && n < 20) begin
      tick();
      smp();
      n++;
    end
    chk("op_grant", 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid[i] = 1'b0;
    smp();
    chk("op_t1_valid", 32'(bus.rsp_valid[i]), 32'd0);
    chk("op_t1_idle", 32'(bus.idle), 32'd0);
    tick();
    smp();
    chk("op_t2_valid", 32'(bus.rsp_valid[i]), 32'd1);
    chk("op_sum", 32'(sum_of(i)), 32'(exp));
    tick();
    bus.rsp_ready[i] = 1'b1;
    smp();
    chk("op_hold", 32'(bus.rsp_valid[i]), 32'd1);
    tick();
    bus.rsp_ready[i] = 1'b0;
    smp();
    chk("op_cleared", 32'(bus.rsp_valid[i]), 32'd0);
    chk("op_idle", 32'(bus.idle), 32'd1);
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    n = 0;
    smp();
    while (!bus.idle && n < 50) begin
      tick();
      smp();
      n++;
    end
    chk(tag, 32'(bus.idle), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] acc;
    int n;
    int ops;
    int cyc;
    int srv [N];

    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = '0;
    apply_reset();

    // Single ops, segment carry and modular wrap
    do_op(0, 16'h1234, 16'h0F0F, 16'h2143);
    do_op(0, 16'hFFFF, 16'h0001, 16'h0000);
    do_op(0, 16'h00FF, 16'h0001, 16'h0100);
    do_op(3, 16'h00FF, 16'hFF01, 16'h0000);
    do_op(2, 16'h7F80, 16'h0080, 16'h8000);

    // Fairness: everyone valid, responses always accepted
    apply_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_x[i*W +: W] = 16'(i * 32'h1111);
      bus.req_y[i*W +: W] = 16'h0101;
    end
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      smp();
      chk("fair_grant", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
      tick();
    end

    // Backpressure on requester 2
    bus.rsp_ready = 4'b1011;
    n = 0;
    smp();
    while (!bus.rsp_valid[2] && n < 20) begin
      tick();
      smp();
      n++;
    end
    for (int i = 0; i < N; i++) srv[i] = 0;
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(bus.rsp_valid[2]), 32'd1);
      chk("bp_sum", 32'(sum_of(2)), 32'h2323);
      chk("bp_no_grant", 32'(bus.req_ready[2]), 32'd0);
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) srv[i]++;
      tick();
      smp();
    end
    chk("bp_served0", 32'(srv[0] >= 2), 32'd1);
    chk("bp_served1", 32'(srv[1] >= 2), 32'd1);
    chk("bp_served3", 32'(srv[3] >= 2), 32'd1);
    tick();
    drain("bp_drain");

    // Reset while a sum for requester 1 is in flight
    bus.req_x[1*W +: W] = 16'h0101;
    bus.req_y[1*W +: W] = 16'h0202;
    bus.req_valid[1] = 1'b1;
    smp();
    n = 0;
    while (!bus.req_ready[1] && n < 20) begin
      tick();
      smp();
      n++;
    end
    chk("rmf_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid[1] = 1'b0;
    smp();
    chk("rmf_busy_idle", 32'(bus.idle), 32'd0);
    #1;
    rst_n = 1'b0;
    bus.req_valid[1] = 1'b1;
    #1;
    chk("rmf_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rmf_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rmf_rsp_sum", bus.rsp_sum[31:0], 32'd0);
    chk("rmf_idle", 32'(bus.idle), 32'd1);
    tick();
    tick();
    bus.req_valid[1] = 1'b0;
    bus.rsp_ready = '1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("rmf_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.rsp_ready = '0;

    // Random traffic; scoreboard checks every response
    ops = 0;
    cyc = 0;
    acc = '0;
    while (ops < 200 && cyc < 4000) begin
      smp();
      acc = bus.req_valid & bus.req_ready;
      ops += $countones(acc);
      tick();
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            bus.req_valid[i]    = 1'b1;
            bus.req_x[i*W +: W] = 16'($urandom);
            bus.req_y[i*W +: W] = 16'($urandom);
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      bus.rsp_ready = 4'($urandom);
    end
    chk("rand_ops_done", 32'(ops >= 200), 32'd1);
    drain("rand_drain");
    chk("rand_sb_empty",
        32'({pend_v[0], pend_v[1], pend_v[2], pend_v[3]}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
